// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: frames one CPU command byte onto the
// open-drain clk/data pair, then reports ack (tx_ok) or failure (tx_err).
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clki,
    input  logic       rst_in,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_ok,
    output logic       tx_err
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned CNT_W = (TO_W > INH_W) ? TO_W : INH_W;
    localparam int unsigned IDX_W = 4;

    localparam logic [CNT_W-1:0] INH_END  = CNT_W'(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_END   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_PAR  = IDX_W'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;

    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             data_meta_q, data_sync_q;
    logic             wr_prev_q;

    logic             fe;
    logic             wr_rise;
    logic             expired;
    logic [CNT_W-1:0] cnt_inc;

    // Line synchronizers; reset to the released (high) level so no false edge appears.
    always_ff @(posedge clki or negedge rst_in) begin
        if (!rst_in) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            wr_prev_q   <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
            wr_prev_q   <= wr_en;
        end
    end

    assign fe      = clk_prev_q & ~clk_sync_q;
    assign wr_rise = wr_en & ~wr_prev_q;

    always_ff @(posedge clki or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
        end
    end

    // Next-state and registered-output logic; oe values always match the state they enter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        par_d     = par_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        ok_d      = ok_q;
        err_d     = err_q;
        cnt_inc   = cnt_q + CNT_W'(1);
        expired   = (cnt_inc == TO_END);

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                cnt_d     = '0;
                if (wr_rise) begin
                    state_d   = S_INHIBIT;
                    byte_d    = wr_data;
                    par_d     = ~^wr_data;
                    ok_d      = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INH_LAST == '0);
                end
            end

            S_INHIBIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= INH_LAST) begin
                    data_oe_d = 1'b1;
                end
                if (cnt_inc == INH_END) begin
                    state_d   = S_REQ;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                end
            end

            S_REQ: begin
                cnt_d = cnt_inc;
                if (fe) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (expired) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    ok_d      = 1'b0;
                    err_d     = 1'b1;
                end
            end

            S_DATA: begin
                cnt_d = cnt_inc;
                if (fe) begin
                    cnt_d = '0;
                    if (idx_q == IDX_PAR) begin
                        data_oe_d = ~par_q;
                        state_d   = S_STOP;
                    end else begin
                        data_oe_d = ~byte_q[idx_q[2:0]];
                        idx_d     = idx_q + IDX_W'(1);
                    end
                end else if (expired) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    ok_d      = 1'b0;
                    err_d     = 1'b1;
                end
            end

            S_STOP: begin
                cnt_d = cnt_inc;
                if (fe) begin
                    state_d   = S_ACK;
                    cnt_d     = '0;
                    data_oe_d = 1'b0;
                end else if (expired) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    ok_d      = 1'b0;
                    err_d     = 1'b1;
                end
            end

            S_ACK: begin
                cnt_d = cnt_inc;
                if (fe) begin
                    state_d = S_WAIT_IDLE;
                    cnt_d   = '0;
                    ok_d    = ~data_sync_q;
                    err_d   = data_sync_q;
                end else if (expired) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    ok_d      = 1'b0;
                    err_d     = 1'b1;
                end
            end

            // Device may still hold the lines after its ack; stay busy until both float high.
            S_WAIT_IDLE: begin
                cnt_d = cnt_inc;
                if (clk_sync_q && data_sync_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (expired) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign tx_ok       = ok_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device drives the
// clock, records the bits it sees on the line and optionally acks.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned TO   = 200;
    localparam int          HALF = 20;

    logic       clki     = 1'b0;
    logic       rst_in   = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_en    = 1'b0;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_ok;
    logic       tx_err;

    // Open-drain wired-AND of host and device.
    wire line_clk  = dev_clk & ~ps2_clk_oe;
    wire line_data = dev_data & ~ps2_data_oe;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clki = ~clki;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clki        (clki),
        .rst_in      (rst_in),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .ps2_clk_in  (line_clk),
        .ps2_data_in (line_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_ok       (tx_ok),
        .tx_err      (tx_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line bits in transmit order: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones  = $countones(b);
        f[0]  = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Write a byte; measure clock-inhibit length and data-low lead before release.
    task automatic start_frame(input logic [7:0] b, output int n_low, output int n_lead);
        @(negedge clki);
        wr_data = b;
        wr_en   = 1'b1;
        n_low   = 0;
        n_lead  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clki);
            if (i == 2) wr_en = 1'b0;
            if (i == 0) chk("busy_after_accept", 32'(busy), 32'd1);
            if (ps2_clk_oe) begin
                n_low++;
                if (ps2_data_oe) n_lead++;
            end else if (n_low > 0) begin
                break;
            end
        end
        wr_en = 1'b0;
    endtask

    // Device side: n_pulses clock pulses, record line data at each rising edge.
    task automatic run_device(input int n_pulses, input bit ack, input bit inject,
                              output logic [10:0] bits);
        bits = '0;
        repeat (10) @(negedge clki);
        for (int p = 1; p <= n_pulses; p++) begin
            if (p == 12 && ack) begin
                dev_data = 1'b0;
                repeat (5) @(negedge clki);
            end
            dev_clk = 1'b0;
            if (inject && p == 5) begin
                wr_data = 8'hAA;
                wr_en   = 1'b1;
            end
            repeat (HALF) @(negedge clki);
            if (inject && p == 5) wr_en = 1'b0;
            dev_clk = 1'b1;
            if (p <= 11) bits[p-1] = line_data;
            repeat (HALF) @(negedge clki);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_not_busy(input string tag);
        int i;
        for (i = 0; i < 400; i++) begin
            if (!busy) break;
            @(negedge clki);
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_frame(input logic [7:0] b, input bit ack, input bit inject);
        int nl, nd;
        logic [10:0] bits;
        start_frame(b, nl, nd);
        chk("inhibit_len", 32'(nl), 32'(INH));
        chk("data_lead", 32'(nd), 32'd1);
        run_device(12, ack, inject, bits);
        chk("frame_bits", 32'(bits), 32'(ref_frame(b)));
        wait_not_busy("frame_end_busy");
        chk("tx_ok", 32'(tx_ok), 32'(ack));
        chk("tx_err", 32'(tx_err), 32'(!ack));
        chk("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    endtask

    initial begin
        int nl, nd, n;
        logic [7:0] b;
        logic [10:0] bits;

        repeat (3) @(negedge clki);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ok_err", 32'({tx_ok, tx_err}), 32'd0);
        rst_in = 1'b1;
        repeat (3) @(negedge clki);

        do_frame(8'hF4, 1'b1, 1'b0);
        do_frame(8'h00, 1'b1, 1'b0);
        do_frame(8'hFF, 1'b1, 1'b0);
        do_frame(8'h01, 1'b1, 1'b0);

        // Device never clocks after request.
        b = 8'($urandom);
        start_frame(b, nl, nd);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clki);
            n++;
            if (!ps2_data_oe) break;
        end
        chk("req_timeout_cycles", 32'(n), 32'(TO));
        chk("req_timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("req_timeout_err", 32'(tx_err), 32'd1);
        chk("req_timeout_ok", 32'(tx_ok), 32'd0);
        chk("req_timeout_busy", 32'(busy), 32'd0);

        do_frame(8'($urandom), 1'b0, 1'b0);

        b = 8'($urandom);
        if (b == 8'hAA) b = 8'h12;
        do_frame(b, 1'b1, 1'b1);

        // Device stops clocking mid-data.
        b = 8'($urandom);
        start_frame(b, nl, nd);
        run_device(3, 1'b0, 1'b0, bits);
        wait_not_busy("data_timeout_busy");
        chk("data_timeout_err", 32'(tx_err), 32'd1);
        chk("data_timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

        for (int k = 0; k < 4; k++) begin
            do_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset while D4 (chosen 0, so data is driven low) is on the line.
        b = 8'($urandom) & 8'hEF;
        start_frame(b, nl, nd);
        run_device(6, 1'b0, 1'b0, bits);
        chk("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #3 rst_in = 1'b0;
        #1;
        chk("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ok_err", 32'({tx_ok, tx_err}), 32'd0);
        repeat (3) @(negedge clki);
        rst_in = 1'b1;
        repeat (3) @(negedge clki);
        chk("post_rst_idle", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
        do_frame(8'hED, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
